mem_map_responder: RTL and testbench

Responder on the shared memory bus for the memory-mapped register window (0xC000–0xFFFF). It services word reads and writes qualified by the bus map-enable. It also contains a prescaled 16-bit timer with compare, overflow flag and interrupt. It sits beside the external SRAM on the bus side of the memory controller and answers whichever circuit currently owns the bus: boot, processor or JTAG.

---
 rtl/mem_map_responder_if.sv | 20 ++
 rtl/mem_map_responder.sv | 113 +++++++++++
 tb/tb_mem_map_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_map_responder_if.sv
// Shared memory-bus signals seen by the mapped-register responder.
// The master modport drives address/control/write data; the slave answers with read data.
interface mem_map_responder_if;
   logic [15:0] busAddr;
   logic        busWr;
   logic        busMapEn;
   logic [15:0] busDataIn;
   logic [15:0] busDataOut;
   logic        busDataDrive;

   modport master (
      output busAddr, busWr, busMapEn, busDataIn,
      input  busDataOut, busDataDrive
   );

   modport slave (
      input  busAddr, busWr, busMapEn, busDataIn,
      output busDataOut, busDataDrive
   );
endinterface

// File: rtl/mem_map_responder.sv
// Memory-mapped register window responder with a prescaled 16-bit compare timer.
// Reads return pre-edge register state one cycle after the access; writes take effect at the access edge.
module mem_map_responder #(
   parameter logic [15:0] CMP_RESET = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_map_responder_if.slave   bus,
   input  logic                 isPaused,
   output logic                 timerIrq
);
   localparam logic [15:0] REG_BASE = 16'hC000;
   localparam int          NUM_REGS = 5;
   localparam logic [15:0] CTRL_WMASK = 16'hFF07;

   logic [15:0] ctrlReg, ctrlNext;
   logic [15:0] countReg, countNext;
   logic [15:0] compareReg;
   logic [15:0] scratchReg;
   logic        ovfReg, ovfNext;
   logic [7:0]  pcntReg, pcntNext;
   logic [15:0] rdDataReg;
   logic        rdDriveReg;
   logic [15:0] rdMux;

   logic        wrEn, rdEn;
   logic [NUM_REGS-1:0] wrSel;
   logic        ctrlEn, ctrlAuto, ctrlIrqEn;
   logic [7:0]  ctrlPrescale;
   logic        tick, wrap;

   assign wrEn = bus.busMapEn & bus.busWr;
   assign rdEn = bus.busMapEn & ~bus.busWr;

   // One-hot write strobes for the five decoded registers (CTRL, COUNT, COMPARE, STATUS, SCRATCH).
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : gWrSel
         assign wrSel[gi] = wrEn && (bus.busAddr == (REG_BASE + 16'(gi)));
      end
   endgenerate

   assign ctrlEn       = ctrlReg[0];
   assign ctrlAuto     = ctrlReg[1];
   assign ctrlIrqEn    = ctrlReg[2];
   assign ctrlPrescale = ctrlReg[15:8];

   assign tick = ctrlEn & ~isPaused & (pcntReg == ctrlPrescale);
   assign wrap = tick & (countReg == compareReg);

   always_comb begin
      ctrlNext  = ctrlReg;
      countNext = countReg;
      ovfNext   = ovfReg;
      pcntNext  = pcntReg;

      // Bus writes are applied last in each group so they override timer-side updates,
      // except OVF where a hardware set must win over write-1-clear.
      if (wrap && !ctrlAuto) ctrlNext[0] = 1'b0;
      if (wrSel[0])          ctrlNext = bus.busDataIn & CTRL_WMASK;

      if (wrSel[0])          pcntNext = 8'd0;
      else if (isPaused)     pcntNext = pcntReg;
      else if (!ctrlEn)      pcntNext = 8'd0;
      else if (tick)         pcntNext = 8'd0;
      else                   pcntNext = pcntReg + 8'd1;

      if (wrap)              countNext = 16'd0;
      else if (tick)         countNext = countReg + 16'd1;
      if (wrSel[1])          countNext = bus.busDataIn;

      if (wrSel[3] && bus.busDataIn[0]) ovfNext = 1'b0;
      if (wrap)              ovfNext = 1'b1;
   end

   always_comb begin
      rdMux = 16'h0000;
      case (bus.busAddr)
         REG_BASE + 16'd0: rdMux = ctrlReg;
         REG_BASE + 16'd1: rdMux = countReg;
         REG_BASE + 16'd2: rdMux = compareReg;
         REG_BASE + 16'd3: rdMux = {15'd0, ovfReg};
         REG_BASE + 16'd4: rdMux = scratchReg;
         default:          rdMux = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrlReg    <= 16'h0000;
         countReg   <= 16'h0000;
         compareReg <= CMP_RESET;
         scratchReg <= 16'h0000;
         ovfReg     <= 1'b0;
         pcntReg    <= 8'd0;
         rdDataReg  <= 16'h0000;
         rdDriveReg <= 1'b0;
      end else begin
         ctrlReg    <= ctrlNext;
         countReg   <= countNext;
         ovfReg     <= ovfNext;
         pcntReg    <= pcntNext;
         if (wrSel[2]) compareReg <= bus.busDataIn;
         if (wrSel[4]) scratchReg <= bus.busDataIn;
         if (rdEn)     rdDataReg  <= rdMux;
         rdDriveReg <= rdEn;
      end
   end

   assign bus.busDataOut   = rdDataReg;
   assign bus.busDataDrive = rdDriveReg;
   assign timerIrq         = ovfReg & ctrlIrqEn;
endmodule

// File: tb/tb_mem_map_responder.sv
// Directed bench for mem_map_responder: bus reads/writes, timer sequencing, collisions and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_mem_map_responder;
   localparam logic [15:0] A_CTRL    = 16'hC000;
   localparam logic [15:0] A_COUNT   = 16'hC001;
   localparam logic [15:0] A_COMPARE = 16'hC002;
   localparam logic [15:0] A_STATUS  = 16'hC003;
   localparam logic [15:0] A_SCRATCH = 16'hC004;

   logic clk;
   logic rst;
   logic isPaused;
   logic timerIrq;
   int   total;
   int   bad;

   mem_map_responder_if busIf ();

   mem_map_responder #(.CMP_RESET(16'hFFFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (busIf),
      .isPaused (isPaused),
      .timerIrq (timerIrq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic idle();
      busIf.busAddr   = 16'h0000;
      busIf.busWr     = 1'b0;
      busIf.busMapEn  = 1'b0;
      busIf.busDataIn = 16'h0000;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      busIf.busAddr   = a;
      busIf.busWr     = 1'b1;
      busIf.busMapEn  = 1'b1;
      busIf.busDataIn = d;
      @(posedge clk); #1;
      idle();
      chk("wr_nodrive", 16'(busIf.busDataDrive), 16'd0);
      $display("write addr=%h data=%h", a, d);
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] expected, input string tag);
      busIf.busAddr   = a;
      busIf.busWr     = 1'b0;
      busIf.busMapEn  = 1'b1;
      busIf.busDataIn = 16'hDEAD;
      @(posedge clk); #1;
      idle();
      chk({tag, "_drv"}, 16'(busIf.busDataDrive), 16'd1);
      chk(tag, busIf.busDataOut, expected);
      $display("read  addr=%h data=%h expect=%h", a, busIf.busDataOut, expected);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      isPaused = 1'b0;
      idle();
      repeat (2) @(posedge clk); #1;
      chk("rst_drive", 16'(busIf.busDataDrive), 16'd0);
      chk("rst_dout", busIf.busDataOut, 16'h0000);
      chk("rst_irq", 16'(timerIrq), 16'd0);
      rst = 1'b0;

      // Reset values, back-to-back reads
      rd(A_CTRL,    16'h0000, "r0_ctrl");
      rd(A_COUNT,   16'h0000, "r0_count");
      rd(A_COMPARE, 16'hFFFF, "r0_compare");
      rd(A_STATUS,  16'h0000, "r0_status");
      rd(A_SCRATCH, 16'h0000, "r0_scratch");
      @(posedge clk); #1;
      chk("idle_nodrive", 16'(busIf.busDataDrive), 16'd0);
      chk("idle_hold", busIf.busDataOut, 16'h0000);

      // Scratch, unmapped addresses, unqualified access
      wr(A_SCRATCH, 16'hA5C3);
      rd(A_SCRATCH, 16'hA5C3, "scratch");
      @(posedge clk); #1;
      chk("hold_last", busIf.busDataOut, 16'hA5C3);
      wr(16'hC00F, 16'h1234);
      rd(16'hC00F, 16'h0000, "unmapped_c00f");
      rd(16'hC005, 16'h0000, "unmapped_c005");
      wr(A_CTRL, 16'hFFFF);
      rd(A_CTRL, 16'hFF07, "ctrl_mask");
      wr(A_CTRL, 16'h0000);
      busIf.busAddr   = A_SCRATCH;
      busIf.busWr     = 1'b1;
      busIf.busMapEn  = 1'b0;
      busIf.busDataIn = 16'hFFFF;
      @(posedge clk); #1;
      chk("nomap_wr_drive", 16'(busIf.busDataDrive), 16'd0);
      busIf.busWr = 1'b0;
      @(posedge clk); #1;
      chk("nomap_rd_drive", 16'(busIf.busDataDrive), 16'd0);
      idle();
      rd(A_SCRATCH, 16'hA5C3, "nomap_unchanged");

      // Auto-reload timer, PRESCALE=0, COMPARE=3
      wr(A_COMPARE, 16'd3);
      wr(A_COUNT, 16'd0);
      wr(A_CTRL, 16'h0003);
      rd(A_COUNT, 16'd0, "t1_c0");
      rd(A_COUNT, 16'd1, "t1_c1");
      rd(A_COUNT, 16'd2, "t1_c2");
      rd(A_COUNT, 16'd3, "t1_c3");
      rd(A_STATUS, 16'd1, "t1_ovf");
      rd(A_COUNT, 16'd1, "t1_running");
      chk("t1_irq_off", 16'(timerIrq), 16'd0);
      wr(A_CTRL, 16'h0007);
      chk("t1_irq_on", 16'(timerIrq), 16'd1);
      wr(A_CTRL, 16'h0000);
      wr(A_STATUS, 16'h0001);
      chk("t1_irq_clr", 16'(timerIrq), 16'd0);

      // One-shot, PRESCALE=2, COMPARE=1 -> OVF after 6 clocks
      wr(A_COMPARE, 16'd1);
      wr(A_COUNT, 16'd0);
      wr(A_CTRL, 16'h0205);
      repeat (5) @(posedge clk); #1;
      chk("t2_irq_early", 16'(timerIrq), 16'd0);
      @(posedge clk); #1;
      chk("t2_irq_set", 16'(timerIrq), 16'd1);
      rd(A_CTRL, 16'h0204, "t2_en_clr");
      rd(A_COUNT, 16'd0, "t2_stopped");
      wr(A_STATUS, 16'h0001);
      chk("t2_irq_clr", 16'(timerIrq), 16'd0);

      // Bus write to COUNT on a tick edge wins
      wr(A_COMPARE, 16'hFFFF);
      wr(A_CTRL, 16'h0003);
      wr(A_COUNT, 16'h0100);
      rd(A_COUNT, 16'h0100, "col_count_wr");
      wr(A_CTRL, 16'h0000);

      // OVF set beats write-1-clear on the same edge
      wr(A_COMPARE, 16'd2);
      wr(A_COUNT, 16'd0);
      wr(A_STATUS, 16'h0001);
      wr(A_CTRL, 16'h0003);
      repeat (2) @(posedge clk); #1;
      wr(A_STATUS, 16'h0001);
      rd(A_STATUS, 16'd1, "col_ovf_wins");
      wr(A_CTRL, 16'h0000);
      wr(A_STATUS, 16'h0001);
      rd(A_STATUS, 16'd0, "ovf_w1c");

      // Pause freezes COUNT and pcnt (PRESCALE=3, pcnt=2 when paused)
      wr(A_COMPARE, 16'hFFFF);
      wr(A_COUNT, 16'd0);
      wr(A_CTRL, 16'h0303);
      repeat (2) @(posedge clk); #1;
      isPaused = 1'b1;
      repeat (9) @(posedge clk); #1;
      rd(A_COUNT, 16'd0, "pause_count");
      isPaused = 1'b0;
      @(posedge clk); #1;
      rd(A_COUNT, 16'd0, "pause_pre_tick");
      rd(A_COUNT, 16'd1, "pause_tick");
      wr(A_CTRL, 16'h0000);

      // Reset during a read data phase
      busIf.busAddr  = A_SCRATCH;
      busIf.busWr    = 1'b0;
      busIf.busMapEn = 1'b1;
      @(posedge clk); #1;
      idle();
      chk("rstmid_drv_before", 16'(busIf.busDataDrive), 16'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_drv", 16'(busIf.busDataDrive), 16'd0);
      chk("rstmid_dout", busIf.busDataOut, 16'h0000);
      #2;
      rst = 1'b0;
      rd(A_CTRL,    16'h0000, "rr_ctrl");
      rd(A_COUNT,   16'h0000, "rr_count");
      rd(A_COMPARE, 16'hFFFF, "rr_compare");
      rd(A_STATUS,  16'h0000, "rr_status");
      rd(A_SCRATCH, 16'h0000, "rr_scratch");
      chk("rr_irq", 16'(timerIrq), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
